// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the instruction ROM: start/run/done handshake, branches, stall, halt.
// Optional macro FETCH_SEQ_INST_COUNT_EN adds the InstCount output (saturating executed-instruction count).
module fetch_sequencer #(
  parameter int A  = 10,
  parameter int OW = 6
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [A-1:0]  StartAddr,
  input  logic          Stall,
  input  logic          Halt,
  input  logic          BranchAbs,
  input  logic [A-1:0]  Target,
  input  logic          BranchRel,
  input  logic [OW-1:0] Offset,
  output logic [A-1:0]  InstAddress,
  output logic          Running,
  output logic          Done
`ifdef FETCH_SEQ_INST_COUNT_EN
  ,
  output logic [15:0]   InstCount
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t         state_r;
  logic [A-1:0]   pc_r;
  logic           running_r;
  logic           done_r;
  logic [A-1:0]   pc_inc_s;
  logic [A-1:0]   pc_rel_s;

  // Sequential and relative next-PC candidates, both modulo 2**A.
  always_comb begin
    pc_inc_s = pc_r + {{(A-1){1'b0}}, 1'b1};
    pc_rel_s = pc_r + {{(A-OW){Offset[OW-1]}}, Offset};
  end

  // Main FSM: state, PC and the registered status flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= IDLE;
      pc_r      <= {A{1'b0}};
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (Start) begin
            state_r   <= RUN;
            pc_r      <= StartAddr;
            running_r <= 1'b1;
            done_r    <= 1'b0;
          end else begin
            pc_r <= pc_r;
          end
        end
        RUN: begin
          // Priority: Stall > Halt > BranchAbs > BranchRel > increment.
          if (Stall) begin
            pc_r <= pc_r;
          end else if (Halt) begin
            state_r   <= DONE;
            running_r <= 1'b0;
            done_r    <= 1'b1;
          end else if (BranchAbs) begin
            pc_r <= Target;
          end else if (BranchRel) begin
            pc_r <= pc_rel_s;
          end else begin
            pc_r <= pc_inc_s;
          end
        end
        default: begin
          state_r   <= IDLE;
          pc_r      <= {A{1'b0}};
          running_r <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign InstAddress = pc_r;
  assign Running     = running_r;
  assign Done        = done_r;

`ifdef FETCH_SEQ_INST_COUNT_EN
  logic [15:0] count_r;
  logic        start_accept_s;
  logic        run_active_s;

  // Qualify counter events from the current state.
  always_comb begin
    start_accept_s = Start && ((state_r == IDLE) || (state_r == DONE));
    run_active_s   = (state_r == RUN) && !Stall;
  end

  // Saturating count of non-stalled RUN cycles, cleared on each accepted Start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_r <= 16'h0000;
    end else if (start_accept_s) begin
      count_r <= 16'h0000;
    end else if (run_active_s && (count_r != 16'hFFFF)) begin
      count_r <= count_r + 16'h0001;
    end else begin
      count_r <= count_r;
    end
  end

  assign InstCount = count_r;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with hand-computed expected PC/status values.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  localparam int A  = 10;
  localparam int OW = 6;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Start;
  logic [A-1:0]  StartAddr;
  logic          Stall;
  logic          Halt;
  logic          BranchAbs;
  logic [A-1:0]  Target;
  logic          BranchRel;
  logic [OW-1:0] Offset;
  logic [A-1:0]  InstAddress;
  logic          Running;
  logic          Done;
`ifdef FETCH_SEQ_INST_COUNT_EN
  logic [15:0]   InstCount;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fetch_sequencer #(.A(A), .OW(OW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .Halt(Halt), .BranchAbs(BranchAbs), .Target(Target),
    .BranchRel(BranchRel), .Offset(Offset), .InstAddress(InstAddress),
    .Running(Running), .Done(Done)
`ifdef FETCH_SEQ_INST_COUNT_EN
    , .InstCount(InstCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_ctl();
    Start = 1'b0; Stall = 1'b0; Halt = 1'b0; BranchAbs = 1'b0; BranchRel = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [A-1:0] pc, input logic run, input logic dn);
    check({tag, "_pc"},   32'(InstAddress), 32'(pc));
    check({tag, "_run"},  32'(Running),     32'(run));
    check({tag, "_done"}, 32'(Done),        32'(dn));
  endtask

  initial begin
    Reset_n = 1'b0; StartAddr = '0; Target = '0; Offset = '0;
    clear_ctl();
    step(); step();
    check_state("reset", 10'd0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    step();
    check_state("idle_hold", 10'd0, 1'b0, 1'b0);

    // Start at 0, four plain fetches, halt at 4
    Start = 1'b1; StartAddr = 10'd0;
    step();
    check_state("start0", 10'd0, 1'b1, 1'b0);
    Start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("seq_pc", 32'(InstAddress), 32'(i));
    end
    Halt = 1'b1;
    step();
    check_state("halt4", 10'd4, 1'b0, 1'b1);
`ifdef FETCH_SEQ_INST_COUNT_EN
    check("count_halt", 32'(InstCount), 32'd5);
`endif
    Halt = 1'b0;
    step();
    check_state("done_hold", 10'd4, 1'b0, 1'b1);
`ifdef FETCH_SEQ_INST_COUNT_EN
    check("count_done_hold", 32'(InstCount), 32'd5);
`endif

    // Restart at 10, abs+rel together (abs wins), then rel -4
    Start = 1'b1; StartAddr = 10'd10;
    step();
    check_state("restart10", 10'd10, 1'b1, 1'b0);
    Start = 1'b0;
    BranchAbs = 1'b1; Target = 10'd200; BranchRel = 1'b1; Offset = 6'b000101;
    step();
    check("abs_wins", 32'(InstAddress), 32'd200);
    BranchAbs = 1'b0; Offset = 6'b111100;
    step();
    check("rel_m4", 32'(InstAddress), 32'd196);
    BranchRel = 1'b0; Start = 1'b1; StartAddr = 10'd300;
    step();
    check_state("start_in_run", 10'd197, 1'b1, 1'b0);
    Start = 1'b0;

    // Halt together with a branch: halt wins, PC holds
    Halt = 1'b1; BranchAbs = 1'b1; Target = 10'd5;
    step();
    check_state("halt_vs_abs", 10'd197, 1'b0, 1'b1);
    clear_ctl();

    // Wrap-around and negative offset below zero
    Start = 1'b1; StartAddr = 10'd1022;
    step();
    check("wrap0", 32'(InstAddress), 32'd1022);
    Start = 1'b0;
    step();
    check("wrap1", 32'(InstAddress), 32'd1023);
    step();
    check("wrap2", 32'(InstAddress), 32'd0);
    step(); step();
    check("pc2", 32'(InstAddress), 32'd2);
    BranchRel = 1'b1; Offset = 6'b111101;
    step();
    check("rel_m3_wrap", 32'(InstAddress), 32'd1023);
    BranchRel = 1'b0;

    // Stall dominates Halt and BranchAbs
    BranchAbs = 1'b1; Target = 10'd50;
    step();
    check("abs50", 32'(InstAddress), 32'd50);
    Stall = 1'b1; Halt = 1'b1; Target = 10'd99;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("stall", 10'd50, 1'b1, 1'b0);
    end
    Stall = 1'b0;
    step();
    check_state("stall_rel_halt", 10'd50, 1'b0, 1'b1);
    clear_ctl();

    // Restart from DONE at PC=7
    Start = 1'b1; StartAddr = 10'd7;
    step();
    Start = 1'b0; Halt = 1'b1;
    step();
    check_state("done7", 10'd7, 1'b0, 1'b1);
    Halt = 1'b0; Start = 1'b1; StartAddr = 10'd100;
    step();
    check_state("restart100", 10'd100, 1'b1, 1'b0);
`ifdef FETCH_SEQ_INST_COUNT_EN
    check("count_cleared", 32'(InstCount), 32'd0);
`endif
    Start = 1'b0;

    // Asynchronous reset mid-RUN at PC=37
    BranchAbs = 1'b1; Target = 10'd37;
    step();
    check("abs37", 32'(InstAddress), 32'd37);
    BranchAbs = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    check_state("async_rst", 10'd0, 1'b0, 1'b0);
    Start = 1'b1; StartAddr = 10'd5;
    step();
    check_state("in_rst", 10'd0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    step();
    check_state("start5", 10'd5, 1'b1, 1'b0);
    Start = 1'b0;
    step();
    check("after5", 32'(InstAddress), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-counter controller that sequences the instruction ROM. It drives the ROM's address input and holds a start/run/done handshake with the testbench or top level. It applies sequential fetch, absolute and relative branches, stalls and halt. It sits between the top-level control, the decoder/branch logic and the combinational-read instruction ROM.

Parameters:
A, 10, PC / ROM address width (ROM depth 2**A)
OW, 6, width of signed relative branch offset

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset_n  input  1  asynchronous active-low reset
Start  input  1  level-sampled request to begin execution at StartAddr
StartAddr  input  A  PC loaded on accepted Start
Stall  input  1  freeze PC and state this cycle
Halt  input  1  decoder reports halt instruction at current PC
BranchAbs  input  1  taken absolute branch
Target  input  A  absolute branch target
BranchRel  input  1  taken relative branch
Offset  input  OW  signed two's-complement relative offset
InstAddress  output  A  registered PC driven to ROM address
Running  output  1  high while in RUN
Done  output  1  high while in DONE

Behaviour:
- Clock and reset: one clock Clk; reset is asynchronous and active-low (Reset_n). Assertion immediately forces state=IDLE, PC=0, Running=0, Done=0, regardless of clock.
- States:
  - IDLE: PC holds. Start=1 at an edge -> RUN, PC<=StartAddr.
  - RUN: per-edge update with priority Stall > Halt > BranchAbs > BranchRel > increment.
    - Stall=1: PC and state hold; all other inputs ignored.
    - Halt=1: -> DONE; PC holds at the halt address.
    - BranchAbs=1: PC<=Target.
    - BranchRel=1: PC<=PC + sign_extend(Offset), modulo 2**A.
    - Otherwise: PC<=PC+1, modulo 2**A; 2**A-1 wraps to 0.
    - Start is ignored in RUN.
  - DONE: PC holds. Start=1 -> RUN, PC<=StartAddr (restart); Done falls on that same edge.
- Output timing:
  - InstAddress = PC register, with no combinational path from inputs. The ROM instruction is valid in the same cycle.
  - Running and Done are decoded from the state register, so they change one edge after the causing event.
  - Done rises on the edge that samples Halt.
- Latency:
  - Start accepted -> first fetch address on InstAddress after 1 edge.
  - Branch -> new PC after 1 edge. No delay slot; the instruction at the branch PC is the only one fetched before the target.
- Simultaneous events:
  - BranchAbs and BranchRel together: BranchAbs wins.
  - Halt with a branch: Halt wins, PC holds.
  - Stall with Halt: neither takes effect; Halt is re-evaluated next cycle.
- Arithmetic: relative target computed in A bits, with Offset sign-extended from OW to A bits and the carry out discarded. For example, PC=2, Offset=-3 with A=10 gives 1023.
- Reset mid-RUN: immediate IDLE with PC=0. A Start held through reset release is accepted on the first edge after release.
- X-safety: inputs other than Start are don't-care outside RUN.

Optional Feature:
FETCH_SEQ_INST_COUNT_EN
- Defined:
  - Adds output InstCount [15:0]: count of non-stalled RUN cycles, including the Halt cycle.
  - Cleared to 0 by reset and on every accepted Start. Saturates at 16'hFFFF.
  - Holds in DONE and IDLE.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset_n=0 mid-RUN at PC=37, asynchronously between edges -> InstAddress=0, Running=0, Done=0 before the next edge. Release, then Start=1, StartAddr=5 -> InstAddress=5, Running=1 after 1 edge.
- Start at StartAddr=0, 4 plain cycles, Halt=1 at PC=4 -> address sequence 0,1,2,3,4, then held at 4. Done=1 and Running=0 after the Halt edge. InstCount=5 when enabled.
- In RUN at PC=10: BranchAbs=1, Target=200 with BranchRel=1 -> PC=200. Then BranchRel=1, Offset=-4 (6'b111100) -> PC=196.
- Wrap: StartAddr=1022 (A=10), two plain cycles -> PC 1022,1023,0. Also PC=2 with Offset=-3 -> PC=1023.
- Stall=1 for 3 cycles at PC=50 with Halt=1 and BranchAbs=1 asserted -> PC stays 50, no DONE. Release Stall with Halt=1 -> DONE at PC=50.
- In DONE at PC=7, Start=1, StartAddr=100 -> Done=0, Running=1, PC=100 after 1 edge. Start pulses during RUN have no effect.
